// File: rtl/vga_pattern_gen_module.sv
// vga_pattern_gen_module: parametrised VGA timing generator with test-pattern engine.
// Ports: CLK pixel clock; RSTn async active-low reset; Mode_Sig pattern select
// (0 bars, 1 grid, 2 checker, 3 bouncing box); VSYNC_Sig/HSYNC_Sig syncs;
// Ready_Sig data enable; Column_Addr_Sig/Row_Addr_Sig active-region address;
// Frame_Sig frame-start pulse; Red_Sig/Green_Sig/Blue_Sig colour channels.
module vga_pattern_gen_module #(
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int H_ACTIVE  = 800,
    parameter int H_FRONT   = 40,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int V_ACTIVE  = 600,
    parameter int V_FRONT   = 1,
    parameter int SYNC_POL  = 1,
    parameter int COLOR_W   = 4,
    parameter int GRID_STEP = 32,
    parameter int CHK_SHIFT = 5,
    parameter int BOX_SIZE  = 64
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [1:0]         Mode_Sig,
    output logic               VSYNC_Sig,
    output logic               HSYNC_Sig,
    output logic               Ready_Sig,
    output logic [10:0]        Column_Addr_Sig,
    output logic [10:0]        Row_Addr_Sig,
    output logic               Frame_Sig,
    output logic [COLOR_W-1:0] Red_Sig,
    output logic [COLOR_W-1:0] Green_Sig,
    output logic [COLOR_W-1:0] Blue_Sig
);
    localparam logic [10:0] H_LAST   = 11'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [10:0] V_LAST   = 11'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [10:0] HS_END   = 11'(H_SYNC);
    localparam logic [10:0] VS_END   = 11'(V_SYNC);
    localparam logic [10:0] HA0      = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] VA0      = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] HA1      = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] VA1      = 11'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [10:0] COL_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] ROW_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] BX_MAX   = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BY_MAX   = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BOX      = 11'(BOX_SIZE);
    localparam logic [10:0] G_LAST   = 11'(GRID_STEP - 1);
    localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);
    localparam logic        POL      = 1'(SYNC_POL);

    logic [1:0]         rst_sync_q, rst_sync_d;
    logic [10:0]        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [10:0]        gx_q, gx_d, gy_q, gy_d, bar_cnt_q, bar_cnt_d;
    logic [3:0]         bar_q, bar_d;
    logic [1:0]         mode_q, mode_d;
    logic [10:0]        box_x_q, box_x_d, box_y_q, box_y_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic               hs_q, hs_d, vs_q, vs_d, rdy_q, rdy_d, frame_q, frame_d;
    logic [10:0]        col_q, col_d, row_q, row_d;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               rst_n, h_wrap, frame_start, act, in_box, grid, pat, pr, pg, pb;
    logic [10:0]        col, row;

    // Reset asserts asynchronously but is released only after two clean clock edges.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) rst_sync_q <= '0;
        else       rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        h_wrap      = h_cnt_q == H_LAST;
        h_cnt_d     = h_wrap ? '0 : h_cnt_q + 11'd1;
        v_cnt_d     = !h_wrap ? v_cnt_q : (v_cnt_q == V_LAST ? '0 : v_cnt_q + 11'd1);
        frame_start = h_cnt_q == '0 && v_cnt_q == '0;
        // Rolling counters stand in for col%GRID_STEP, row%GRID_STEP and col/(H_ACTIVE/8);
        // each is zeroed on the cycle before the active window starts.
        gx_d        = (h_cnt_d == HA0 || gx_q == G_LAST) ? '0 : gx_q + 11'd1;
        gy_d        = !h_wrap ? gy_q : ((v_cnt_d == VA0 || gy_q == G_LAST) ? '0 : gy_q + 11'd1);
        bar_cnt_d   = (h_cnt_d == HA0 || bar_cnt_q == BAR_LAST) ? '0 : bar_cnt_q + 11'd1;
        bar_d       = h_cnt_d == HA0 ? '0 :
                      (bar_cnt_q == BAR_LAST && !bar_q[3]) ? bar_q + 4'd1 : bar_q;
        mode_d      = frame_start ? Mode_Sig : mode_q;
        // Flipping the direction first makes the edge step land one pixel back inside.
        dir_x_d     = frame_start && (dir_x_q ? box_x_q == BX_MAX : box_x_q == '0) ? ~dir_x_q : dir_x_q;
        dir_y_d     = frame_start && (dir_y_q ? box_y_q == BY_MAX : box_y_q == '0) ? ~dir_y_q : dir_y_q;
        box_x_d     = !frame_start ? box_x_q : (dir_x_d ? box_x_q + 11'd1 : box_x_q - 11'd1);
        box_y_d     = !frame_start ? box_y_q : (dir_y_d ? box_y_q + 11'd1 : box_y_q - 11'd1);
        col         = h_cnt_q - HA0;
        row         = v_cnt_q - VA0;
        act         = h_cnt_q >= HA0 && h_cnt_q < HA1 && v_cnt_q >= VA0 && v_cnt_q < VA1;
        in_box      = col >= box_x_q && col < box_x_q + BOX && row >= box_y_q && row < box_y_q + BOX;
        grid        = gx_q == '0 || gy_q == '0 || col == COL_LAST || row == ROW_LAST;
        pat         = mode_q[0] ? grid : col[CHK_SHIFT] ^ row[CHK_SHIFT];
        // Bar index 0..7 maps to white..black through its inverted bits; 8 is the black remainder.
        pr          = mode_q == 2'd0 ? ~bar_q[3] & ~bar_q[1] : (mode_q == 2'd3 ? in_box : pat);
        pg          = mode_q == 2'd0 ? ~bar_q[3] & ~bar_q[2] : (mode_q == 2'd3 ? 1'b0 : pat);
        pb          = mode_q == 2'd0 ? ~bar_q[3] & ~bar_q[0] : (mode_q == 2'd3 ? ~in_box : pat);
        hs_d        = h_cnt_q < HS_END ? POL : ~POL;
        vs_d        = v_cnt_q < VS_END ? POL : ~POL;
        rdy_d       = act;
        col_d       = act ? col : '0;
        row_d       = act ? row : '0;
        frame_d     = frame_start;
        red_d       = {COLOR_W{act & pr}};
        green_d     = {COLOR_W{act & pg}};
        blue_d      = {COLOR_W{act & pb}};
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            bar_cnt_q <= '0;
            bar_q     <= '0;
            mode_q    <= '0;
            box_x_q   <= '0;
            box_y_q   <= '0;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            hs_q      <= ~POL;
            vs_q      <= ~POL;
            rdy_q     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            frame_q   <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            bar_cnt_q <= bar_cnt_d;
            bar_q     <= bar_d;
            mode_q    <= mode_d;
            box_x_q   <= box_x_d;
            box_y_q   <= box_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rdy_q     <= rdy_d;
            col_q     <= col_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign HSYNC_Sig       = hs_q;
    assign VSYNC_Sig       = vs_q;
    assign Ready_Sig       = rdy_q;
    assign Column_Addr_Sig = col_q;
    assign Row_Addr_Sig    = row_q;
    assign Frame_Sig       = frame_q;
    assign Red_Sig         = red_q;
    assign Green_Sig       = green_q;
    assign Blue_Sig        = blue_q;
endmodule

// File: tb/tb_vga_pattern_gen_module.sv
// tb_vga_pattern_gen_module: directed scoreboard bench for three configurations of the generator.
module tb_vga_pattern_gen_module;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b1;
    logic [1:0]  mode [3];
    logic        hs [3], vs [3], rdy [3], frm [3];
    logic [10:0] col [3], row [3];
    logic [3:0]  r [3], g [3], b [3];
    logic [23:0] sb [$];
    int          vectors = 0, miscompares = 0, n = 0;
    int          bx = 0, by = 0, dx = 1, dy = 1;

    always #5 CLK = ~CLK;

    vga_pattern_gen_module u0 (
        .CLK(CLK), .RSTn(RSTn), .Mode_Sig(mode[0]), .VSYNC_Sig(vs[0]), .HSYNC_Sig(hs[0]),
        .Ready_Sig(rdy[0]), .Column_Addr_Sig(col[0]), .Row_Addr_Sig(row[0]), .Frame_Sig(frm[0]),
        .Red_Sig(r[0]), .Green_Sig(g[0]), .Blue_Sig(b[0]));

    vga_pattern_gen_module #(
        .H_SYNC(4), .H_BACK(4), .H_ACTIVE(64), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(48), .V_FRONT(2),
        .SYNC_POL(0), .BOX_SIZE(16)
    ) u1 (
        .CLK(CLK), .RSTn(RSTn), .Mode_Sig(mode[1]), .VSYNC_Sig(vs[1]), .HSYNC_Sig(hs[1]),
        .Ready_Sig(rdy[1]), .Column_Addr_Sig(col[1]), .Row_Addr_Sig(row[1]), .Frame_Sig(frm[1]),
        .Red_Sig(r[1]), .Green_Sig(g[1]), .Blue_Sig(b[1]));

    vga_pattern_gen_module #(
        .H_SYNC(1), .H_BACK(1), .H_ACTIVE(24), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(20), .V_FRONT(1),
        .BOX_SIZE(16)
    ) u2 (
        .CLK(CLK), .RSTn(RSTn), .Mode_Sig(mode[2]), .VSYNC_Sig(vs[2]), .HSYNC_Sig(hs[2]),
        .Ready_Sig(rdy[2]), .Column_Addr_Sig(col[2]), .Row_Addr_Sig(row[2]), .Frame_Sig(frm[2]),
        .Red_Sig(r[2]), .Green_Sig(g[2]), .Blue_Sig(b[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int m);
        while (n < m) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic wait_frame(input int k, input int budget);
        int c = 0;
        do begin
            @(negedge CLK);
            c++;
        end while (frm[k] !== 1'b1 && c < budget);
        chk($sformatf("frame_pulse_u%0d", k), 32'(frm[k]), 32'd1);
        n = 0;
    endtask

    task automatic px(input string tag, input int k, input int m, input logic [11:0] exp);
        go(m);
        chk(tag, 32'({r[k], g[k], b[k]}), 32'(exp));
    endtask

    function automatic logic [11:0] bar_rgb(input int c);
        logic [2:0] tbl [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        logic [2:0] t;
        if (c / 100 >= 8) return 12'h000;
        t = tbl[c / 100];
        return {{4{t[2]}}, {4{t[1]}}, {4{t[0]}}};
    endfunction

    function automatic int p1(input int c, input int rr);
        return (4 + rr) * 76 + 8 + c;
    endfunction

    function automatic int p2(input int c, input int rr);
        return (2 + rr) * 27 + 2 + c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] e;
        int          base;
        bit          w;
        mode[0] = 2'd0;
        mode[1] = 2'd1;
        mode[2] = 2'd3;
        #1 RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_hsync", 32'(hs[0]), 32'd0);
        chk("rst_vsync", 32'(vs[0]), 32'd0);
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_frame", 32'(frm[0]), 32'd0);
        chk("rst_rgb", 32'({r[0], g[0], b[0]}), 32'd0);
        chk("rst_addr", 32'({col[0], row[0]}), 32'd0);
        RSTn = 1'b1;
        wait_frame(0, 8);
        chk("hs_start", 32'(hs[0]), 32'd1);
        go(1);
        chk("frame_one_cycle", 32'(frm[0]), 32'd0);
        go(127);
        chk("hs_last", 32'(hs[0]), 32'd1);
        go(128);
        chk("hs_off", 32'(hs[0]), 32'd0);
        go(4 * 1056 - 1);
        chk("vs_last", 32'(vs[0]), 32'd1);
        go(4 * 1056);
        chk("vs_off", 32'(vs[0]), 32'd0);
        base = 27 * 1056 + 216;
        go(base - 1);
        chk("ready_before", 32'(rdy[0]), 32'd0);
        for (int i = 0; i <= 800; i++)
            sb.push_back(i < 800 ? {1'b1, 11'(i), bar_rgb(i)} : 24'd0);
        for (int i = 0; i <= 800; i++) begin
            go(base + i);
            e = sb.pop_front();
            chk($sformatf("bars_col%0d", i), 32'({rdy[0], col[0], r[0], g[0], b[0]}), 32'(e));
        end
        wait_frame(1, 4200);
        chk("pol_hs_active", 32'({hs[1], vs[1]}), 32'd0);
        go(3);
        chk("pol_hs_last", 32'(hs[1]), 32'd0);
        go(4);
        chk("pol_hs_idle", 32'(hs[1]), 32'd1);
        go(75);
        chk("pol_hs_end", 32'(hs[1]), 32'd1);
        go(76);
        chk("pol_hs_period", 32'(hs[1]), 32'd0);
        go(151);
        chk("pol_vs_last", 32'(vs[1]), 32'd0);
        go(152);
        chk("pol_vs_idle", 32'(vs[1]), 32'd1);
        for (int i = 0; i <= 64; i++) begin
            w = (i % 32 == 0) || i == 63;
            sb.push_back(i < 64 ? {1'b1, 11'(i), {12{w}}} : 24'd0);
        end
        for (int i = 0; i <= 64; i++) begin
            go(p1(i, 1));
            e = sb.pop_front();
            chk($sformatf("grid_row1_col%0d", i), 32'({rdy[1], col[1], r[1], g[1], b[1]}), 32'(e));
        end
        chk("grid_row_addr", 32'(row[1]), 32'd0);
        mode[1] = 2'd2;
        px("grid_persists_40_10", 1, p1(40, 10), 12'h000);
        px("grid_row32", 1, p1(5, 32), 12'hFFF);
        px("grid_row47", 1, p1(5, 47), 12'hFFF);
        wait_frame(1, 4200);
        px("chk_32_0", 1, p1(32, 0), 12'hFFF);
        px("chk_5_10", 1, p1(5, 10), 12'h000);
        px("chk_40_10", 1, p1(40, 10), 12'hFFF);
        px("chk_32_32", 1, p1(32, 32), 12'h000);
        go(p1(10, 40));
        chk("pre_reset_ready", 32'(rdy[1]), 32'd1);
        #2 RSTn = 1'b0;
        #1;
        chk("async_ready", 32'(rdy[1]), 32'd0);
        chk("async_hs", 32'({hs[1], vs[1]}), 32'd3);
        chk("async_rgb", 32'({r[1], g[1], b[1]}), 32'd0);
        chk("async_addr", 32'({col[1], row[1]}), 32'd0);
        chk("async_hs_u0", 32'(hs[0]), 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        wait_frame(1, 6);
        chk("restart_u2_frame", 32'(frm[2]), 32'd1);
        chk("restart_hs", 32'(hs[1]), 32'd0);
        for (int f = 0; f < 12; f++) begin
            if (f > 0) wait_frame(2, 700);
            if (dx == 1 && bx == 8) begin dx = -1; bx = 7; end
            else if (dx == -1 && bx == 0) begin dx = 1; bx = 1; end
            else bx += dx;
            if (dy == 1 && by == 4) begin dy = -1; by = 3; end
            else if (dy == -1 && by == 0) begin dy = 1; by = 1; end
            else by += dy;
            if (bx > 0) begin
                px($sformatf("box_f%0d_left_bg", f), 2, p2(bx - 1, by), 12'h00F);
                px($sformatf("box_f%0d_corner", f), 2, p2(bx, by), 12'hF00);
            end else begin
                px($sformatf("box_f%0d_corner", f), 2, p2(bx, by), 12'hF00);
                px($sformatf("box_f%0d_right_bg", f), 2, p2(bx + 16, by), 12'h00F);
            end
            px($sformatf("box_f%0d_far", f), 2, p2(bx + 15, by + 15), 12'hF00);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
